// File: rtl/button_debouncer_if.sv
// Button debouncer bus: raw button level in, clean level and strobes out.
//   RawButton : asynchronous raw button level, 1 = pressed
//   Debounced : registered debounced level
//   Rise      : one-cycle strobe on an accepted press
//   Fall      : one-cycle strobe on an accepted release
//   Repeat    : one-cycle auto-repeat strobe while held (0 when auto-repeat is not built)
// The master modport is the debouncer itself. The slave modport is the button source and downstream consumer.
interface button_debouncer_if;
    logic RawButton;
    logic Debounced;
    logic Rise;
    logic Fall;
    logic Repeat;

    modport master (input RawButton, output Debounced, Rise, Fall, Repeat);
    modport slave  (output RawButton, input Debounced, Rise, Fall, Repeat);
endinterface

// File: rtl/button_debouncer.sv
// Synchronizes and debounces one mechanical push-button into a clean level.
// It also produces single-cycle press/release strobes.
// Debounced feeds the downstream falling-edge one-shot, so that stage only sees bounce-free edges.
// Ports:
//   CLOCK : single clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : button_debouncer_if.master (RawButton in; Debounced/Rise/Fall/Repeat out)
// Optional feature: define AUTO_REPEAT_EN to build the held-button auto-repeat strobe.
// Otherwise Repeat is tied to 0, and REPEAT_DELAY/REPEAT_PERIOD/RPT_W are ignored.
// A new level is accepted on edge DEBOUNCE_CYCLES+3 after it is first sampled.
// That total is 2 synchronizer edges, 1 edge to leave the stable state and DEBOUNCE_CYCLES qualifying edges.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned RPT_W           = 26
) (
    input logic                CLOCK,
    input logic                Reset,
    button_debouncer_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } StateT;

    StateT            state;
    StateT            stateNext;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;
    logic             Sync1;
    logic             Sync2;
    logic             debouncedQ;
    logic             debouncedNext;
    logic             riseQ;
    logic             riseNext;
    logic             fallQ;
    logic             fallNext;

    // Two-flop synchronizer on the asynchronous button input
    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            Sync1 <= 1'b0;
            Sync2 <= 1'b0;
        end else begin
            Sync1 <= bus.RawButton;
            Sync2 <= Sync1;
        end
    end

    // State, qualification counter and registered outputs
    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            state      <= LOW;
            count      <= '0;
            debouncedQ <= 1'b0;
            riseQ      <= 1'b0;
            fallQ      <= 1'b0;
        end else begin
            state      <= stateNext;
            count      <= countNext;
            debouncedQ <= debouncedNext;
            riseQ      <= riseNext;
            fallQ      <= fallNext;
        end
    end

    // Next-state logic. The counter stops at its terminal compare, so it never wraps.
    always_comb begin
        stateNext     = state;
        countNext     = count;
        debouncedNext = debouncedQ;
        riseNext      = 1'b0;
        fallNext      = 1'b0;
        unique case (state)
            LOW: begin
                if (Sync2) begin
                    stateNext = WAIT_HIGH;
                    countNext = '0;
                end
            end
            WAIT_HIGH: begin
                if (!Sync2) begin
                    stateNext = LOW;
                    countNext = '0;
                end else if (count == CNT_LAST) begin
                    stateNext     = HIGH;
                    countNext     = '0;
                    debouncedNext = 1'b1;
                    riseNext      = 1'b1;
                end else begin
                    countNext = count + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!Sync2) begin
                    stateNext = WAIT_LOW;
                    countNext = '0;
                end
            end
            WAIT_LOW: begin
                if (Sync2) begin
                    stateNext = HIGH;
                    countNext = '0;
                end else if (count == CNT_LAST) begin
                    stateNext     = LOW;
                    countNext     = '0;
                    debouncedNext = 1'b0;
                    fallNext      = 1'b1;
                end else begin
                    countNext = count + CNT_W'(1);
                end
            end
            default: begin
                stateNext = LOW;
                countNext = '0;
            end
        endcase
    end

    assign bus.Debounced = debouncedQ;
    assign bus.Rise      = riseQ;
    assign bus.Fall      = fallQ;

`ifdef AUTO_REPEAT_EN
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rptCount;
    logic [RPT_W-1:0] rptCountNext;
    logic             rptPeriodic;
    logic             rptPeriodicNext;
    logic             repeatQ;
    logic             repeatNext;

    // Repeat timer: the first interval is REPEAT_DELAY and later intervals are REPEAT_PERIOD.
    // It runs only in HIGH and holds its value through a WAIT_LOW dip.
    always_comb begin
        rptCountNext    = rptCount;
        rptPeriodicNext = rptPeriodic;
        repeatNext      = 1'b0;
        if (riseNext || fallNext) begin
            rptCountNext    = '0;
            rptPeriodicNext = 1'b0;
        end else if (state == HIGH) begin
            if (rptCount == (rptPeriodic ? PERIOD_LAST : DELAY_LAST)) begin
                rptCountNext    = '0;
                rptPeriodicNext = 1'b1;
                repeatNext      = 1'b1;
            end else begin
                rptCountNext = rptCount + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            rptCount    <= '0;
            rptPeriodic <= 1'b0;
            repeatQ     <= 1'b0;
        end else begin
            rptCount    <= rptCountNext;
            rptPeriodic <= rptPeriodicNext;
            repeatQ     <= repeatNext;
        end
    end

    assign bus.Repeat = repeatQ;
`else
    // Repeat parameters are only meaningful with auto-repeat built in
    logic unusedRepeatCfg;
    assign unusedRepeatCfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD), 32'(RPT_W)};
    assign bus.Repeat      = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10 and REPEAT_PERIOD=5.
// Edge k means the k-th rising edge after RawButton changes. Outputs are sampled 1 time unit after each rising edge.
module tb_button_debouncer;

    logic CLOCK;
    logic Reset;
    int   testsRun;
    int   testsFailed;

    button_debouncer_if bif();

    button_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (20),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5),
        .RPT_W           (26)
    ) dut (
        .CLOCK (CLOCK),
        .Reset (Reset),
        .bus   (bif)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic test_reset();
        logic expRise;
        logic expDeb;
        Reset         = 1'b0;
        bif.RawButton = 1'b1;
        repeat (3) tick();
        testsRun++;
        if ({bif.Debounced, bif.Rise, bif.Fall, bif.Repeat} !== 4'b0000) begin
            testsFailed++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {bif.Debounced, bif.Rise, bif.Fall, bif.Repeat});
        end
        Reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            expRise = (k == 7);
            expDeb  = (k >= 7);
            testsRun++;
            if (bif.Rise !== expRise || bif.Debounced !== expDeb || bif.Fall !== 1'b0) begin
                testsFailed++;
                $display("FAIL reset_requalify edge %0d: got rise=%b deb=%b fall=%b expected rise=%b deb=%b fall=0",
                         k, bif.Rise, bif.Debounced, bif.Fall, expRise, expDeb);
            end
        end
    endtask

    task automatic test_clean();
        logic levels [3];
        logic expRise;
        logic expFall;
        logic expDeb;
        levels[0] = 1'b0;
        levels[1] = 1'b1;
        levels[2] = 1'b0;
        for (int p = 0; p < 3; p++) begin
            bif.RawButton = levels[p];
            for (int k = 1; k <= 8; k++) begin
                tick();
                expRise = levels[p] && (k == 7);
                expFall = !levels[p] && (k == 7);
                expDeb  = (k >= 7) ? levels[p] : !levels[p];
                testsRun++;
                if (bif.Rise !== expRise || bif.Fall !== expFall || bif.Debounced !== expDeb) begin
                    testsFailed++;
                    $display("FAIL clean phase %0d edge %0d: got rise=%b fall=%b deb=%b expected rise=%b fall=%b deb=%b",
                             p, k, bif.Rise, bif.Fall, bif.Debounced, expRise, expFall, expDeb);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic expRise;
        for (int k = 0; k < 20; k++) begin
            bif.RawButton = ((k / 2) % 2 == 0);
            tick();
            testsRun++;
            if (bif.Rise !== 1'b0 || bif.Debounced !== 1'b0) begin
                testsFailed++;
                $display("FAIL bounce_toggle cycle %0d: got rise=%b deb=%b expected rise=0 deb=0",
                         k, bif.Rise, bif.Debounced);
            end
        end
        bif.RawButton = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            expRise = (k == 7);
            testsRun++;
            if (bif.Rise !== expRise || bif.Debounced !== (k >= 7)) begin
                testsFailed++;
                $display("FAIL bounce_settle edge %0d: got rise=%b deb=%b expected rise=%b deb=%b",
                         k, bif.Rise, bif.Debounced, expRise, (k >= 7));
            end
        end
    endtask

    task automatic test_glitch();
        bif.RawButton = 1'b0;
        tick();
        bif.RawButton = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            testsRun++;
            if (bif.Debounced !== 1'b1 || bif.Fall !== 1'b0) begin
                testsFailed++;
                $display("FAIL glitch_high edge %0d: got deb=%b fall=%b expected deb=1 fall=0",
                         k, bif.Debounced, bif.Fall);
            end
        end
        bif.RawButton = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            testsRun++;
            if (bif.Fall !== (k == 7) || bif.Debounced !== (k < 7)) begin
                testsFailed++;
                $display("FAIL glitch_release edge %0d: got fall=%b deb=%b expected fall=%b deb=%b",
                         k, bif.Fall, bif.Debounced, (k == 7), (k < 7));
            end
        end
    endtask

    task automatic test_mid_reset();
        bif.RawButton = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            testsRun++;
            if (bif.Rise !== 1'b0 || bif.Debounced !== 1'b0) begin
                testsFailed++;
                $display("FAIL midreset_qualify edge %0d: got rise=%b deb=%b expected rise=0 deb=0",
                         k, bif.Rise, bif.Debounced);
            end
        end
        Reset = 1'b0;
        #1;
        testsRun++;
        if ({bif.Debounced, bif.Rise, bif.Fall, bif.Repeat} !== 4'b0000) begin
            testsFailed++;
            $display("FAIL midreset_assert: got %b expected 0000",
                     {bif.Debounced, bif.Rise, bif.Fall, bif.Repeat});
        end
        tick();
        tick();
        bif.RawButton = 1'b0;
        Reset         = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            testsRun++;
            if (bif.Rise !== 1'b0 || bif.Debounced !== 1'b0) begin
                testsFailed++;
                $display("FAIL midreset_after edge %0d: got rise=%b deb=%b expected rise=0 deb=0",
                         k, bif.Rise, bif.Debounced);
            end
        end
    endtask

    task automatic test_repeat();
        logic expRep;
        bif.RawButton = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            testsRun++;
            if (bif.Rise !== (k == 7) || bif.Repeat !== 1'b0) begin
                testsFailed++;
                $display("FAIL repeat_press edge %0d: got rise=%b rep=%b expected rise=%b rep=0",
                         k, bif.Rise, bif.Repeat, (k == 7));
            end
        end
        for (int k = 1; k <= 30; k++) begin
            tick();
`ifdef AUTO_REPEAT_EN
            expRep = (k >= 10) && (k % 5 == 0);
`else
            expRep = 1'b0;
`endif
            testsRun++;
            if (bif.Repeat !== expRep || bif.Rise !== 1'b0) begin
                testsFailed++;
                $display("FAIL repeat_hold +%0d: got rep=%b rise=%b expected rep=%b rise=0",
                         k, bif.Repeat, bif.Rise, expRep);
            end
        end
        bif.RawButton = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            testsRun++;
            if (bif.Repeat !== 1'b0 || bif.Fall !== (k == 7)) begin
                testsFailed++;
                $display("FAIL repeat_release edge %0d: got rep=%b fall=%b expected rep=0 fall=%b",
                         k, bif.Repeat, bif.Fall, (k == 7));
            end
        end
    endtask

    initial begin
        CLOCK         = 1'b0;
        Reset         = 1'b0;
        bif.RawButton = 1'b0;
        testsRun      = 0;
        testsFailed   = 0;
        test_reset();
        test_clean();
        test_bounce();
        test_glitch();
        test_mid_reset();
        test_repeat();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
